// File: rtl/parser_pipe.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// parser_pipe
//   Header parser placed between the packet input and match-action stage 0.
//   It captures the first HDR_SEGS beats of each packet, reads a per-VLAN entry
//   of NUM_ACT parse actions from an internal table and runs every action in
//   parallel. Each action copies a 2/4/6-byte field into one of 24 PHV
//   containers (8 of each size). The PHV is then offered on a valid/ready
//   handshake. Any packet beats beyond the header are drained afterwards.
//
//   Build option: PARSER_BYTE_SWAP_EN
//     defined   - each container is byte-reversed at phv_out
//                 (network order, first wire byte in the MSBs)
//     undefined - containers are emitted in raw buffer order
//                 (first wire byte in bits [7:0])
//
// Ports
//   axis_clk, aresetn            clock, asynchronous active-low reset
//   s_axis_t{data,user,keep,     packet AXI-Stream slave (tkeep is ignored)
//           valid,last,ready}
//   phv_valid/phv_ready/phv_out  PHV handshake
//                                {6B[7..0], 4B[7..0], 2B[7..0], vlan_id, tuser_1st}
//   tbl_wr_en/addr/data          action-table write port, usable in any state
// -----------------------------------------------------------------------------
module parser_pipe #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int HDR_SEGS             = 4,
  parameter int NUM_ACT              = 10,
  parameter int TBL_AW               = 4,
  parameter int PHV_LEN              = 8*(48+32+16)+12+C_S_AXIS_TUSER_WIDTH
) (
  input  logic                              axis_clk,
  input  logic                              aresetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic                              s_axis_tvalid,
  input  logic                              s_axis_tlast,
  output logic                              s_axis_tready,
  output logic                              phv_valid,
  input  logic                              phv_ready,
  output logic [PHV_LEN-1:0]                phv_out,
  input  logic                              tbl_wr_en,
  input  logic [TBL_AW-1:0]                 tbl_wr_addr,
  input  logic [16*NUM_ACT-1:0]             tbl_wr_data
);

  localparam int DW        = C_S_AXIS_DATA_WIDTH;
  localparam int TUW       = C_S_AXIS_TUSER_WIDTH;
  localparam int BUF_W     = HDR_SEGS * DW;
  localparam int PAD_W     = BUF_W + 48;
  localparam int TBL_DW    = 16 * NUM_ACT;
  localparam int TBL_DEPTH = 1 << TBL_AW;
  localparam int C2_LSB    = TUW + 12;
  localparam int C4_LSB    = C2_LSB + 8*16;
  localparam int C6_LSB    = C4_LSB + 8*32;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CAPTURE, ST_LOOKUP, ST_EXTRACT, ST_OUTPUT, ST_DRAIN
  } state_t;

  state_t              r_state;
  logic                r_tready;
  logic                r_phv_valid;
  logic [PHV_LEN-1:0]  r_phv_out;
  logic [BUF_W-1:0]    r_buf;
  logic [TUW-1:0]      r_tuser_1st;
  logic [2:0]          r_seg;
  logic                r_tail_pending;
  logic [15:0]         r_c2 [8];
  logic [31:0]         r_c4 [8];
  logic [47:0]         r_c6 [8];

  logic [TBL_DW-1:0]   r_tbl_mem [TBL_DEPTH];
  logic [TBL_DW-1:0]   r_tbl_rd_data;

  logic                w_beat;
  logic [TBL_AW-1:0]   w_tbl_rd_addr;
  logic [PAD_W-1:0]    w_pad;
  logic [12:0]         w_act;
  logic [47:0]         w_field;
  logic [15:0]         w_c2_next [8];
  logic [31:0]         w_c4_next [8];
  logic [47:0]         w_c6_next [8];
  logic [7:0][15:0]    w_c2_o;
  logic [7:0][31:0]    w_c4_o;
  logic [7:0][47:0]    w_c6_o;
  logic [PHV_LEN-1:0]  w_phv_asm;
  logic                w_unused;

  assign s_axis_tready = r_tready;
  assign phv_valid     = r_phv_valid;
  assign phv_out       = r_phv_out;

  assign w_beat        = s_axis_tvalid & r_tready;
  // vlan_id sits at buffer[116+:12]; its upper bits select the table entry
  assign w_tbl_rd_addr = r_buf[116+4 +: TBL_AW];
  // Zero padding lets a 6-byte window start anywhere in the buffer
  assign w_pad         = {48'd0, r_buf};
  // tkeep and the reserved action bits [15:13] carry nothing we use
  assign w_unused      = ^{s_axis_tkeep, r_tbl_rd_data};

  // A field is only taken when it lies wholly inside the header buffer
  function automatic logic fits(input logic [6:0] off, input int size);
    int v_end;
    v_end = 8 * int'(off) + size;
    return (v_end <= BUF_W);
  endfunction

  // Action table: plain array, registered read, read-before-write on collision
  always_ff @(posedge axis_clk) begin
    if (tbl_wr_en)
      r_tbl_mem[tbl_wr_addr] <= tbl_wr_data;
    if (r_state == ST_LOOKUP)
      r_tbl_rd_data <= r_tbl_mem[w_tbl_rd_addr];
  end

  // All actions evaluated in parallel; ascending loop order means the highest
  // action index wins when several actions target the same container.
  always_comb begin
    w_act   = '0;
    w_field = '0;
    for (int c = 0; c < 8; c++) begin
      w_c2_next[c] = r_c2[c];
      w_c4_next[c] = r_c4[c];
      w_c6_next[c] = r_c6[c];
    end
    for (int i = 0; i < NUM_ACT; i++) begin
      w_act   = r_tbl_rd_data[16*i +: 13];
      w_field = 48'(w_pad >> {w_act[12:6], 3'b000});
      if (w_act[0]) begin
        case (w_act[2:1])
          2'b01: w_c2_next[w_act[5:3]] = fits(w_act[12:6], 16) ? w_field[15:0] : 16'd0;
          2'b10: w_c4_next[w_act[5:3]] = fits(w_act[12:6], 32) ? w_field[31:0] : 32'd0;
          2'b11: w_c6_next[w_act[5:3]] = fits(w_act[12:6], 48) ? w_field : 48'd0;
          default: ;
        endcase
      end
    end
  end

  // Container output ordering and PHV assembly
  genvar gi, gj;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_cont
`ifdef PARSER_BYTE_SWAP_EN
      for (gj = 0; gj < 2; gj++) begin : g_sw2
        assign w_c2_o[gi][8*gj +: 8] = r_c2[gi][8*(1-gj) +: 8];
      end
      for (gj = 0; gj < 4; gj++) begin : g_sw4
        assign w_c4_o[gi][8*gj +: 8] = r_c4[gi][8*(3-gj) +: 8];
      end
      for (gj = 0; gj < 6; gj++) begin : g_sw6
        assign w_c6_o[gi][8*gj +: 8] = r_c6[gi][8*(5-gj) +: 8];
      end
`else
      assign w_c2_o[gi] = r_c2[gi];
      assign w_c4_o[gi] = r_c4[gi];
      assign w_c6_o[gi] = r_c6[gi];
`endif
      assign w_phv_asm[C2_LSB + 16*gi +: 16] = w_c2_o[gi];
      assign w_phv_asm[C4_LSB + 32*gi +: 32] = w_c4_o[gi];
      assign w_phv_asm[C6_LSB + 48*gi +: 48] = w_c6_o[gi];
    end
  endgenerate

  assign w_phv_asm[TUW +: 12]  = r_buf[116 +: 12];
  assign w_phv_asm[TUW-1:0]    = r_tuser_1st;

  // Main control FSM with registered outputs
  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state        <= ST_IDLE;
      r_tready       <= 1'b0;
      r_phv_valid    <= 1'b0;
      r_phv_out      <= '0;
      r_buf          <= '0;
      r_tuser_1st    <= '0;
      r_seg          <= '0;
      r_tail_pending <= 1'b0;
      for (int c = 0; c < 8; c++) begin
        r_c2[c] <= '0;
        r_c4[c] <= '0;
        r_c6[c] <= '0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tready <= 1'b1;
          if (w_beat) begin
            // New packet: wipe the buffer so short packets leave zeros behind,
            // then drop beat 0 into segment 0.
            r_buf         <= '0;
            r_buf[DW-1:0] <= s_axis_tdata;
            r_tuser_1st   <= s_axis_tuser;
            r_seg         <= 3'd1;
            for (int c = 0; c < 8; c++) begin
              r_c2[c] <= '0;
              r_c4[c] <= '0;
              r_c6[c] <= '0;
            end
            if (s_axis_tlast || HDR_SEGS == 1) begin
              r_tail_pending <= ~s_axis_tlast;
              r_tready       <= 1'b0;
              r_state        <= ST_LOOKUP;
            end else begin
              r_state <= ST_CAPTURE;
            end
          end
        end
        ST_CAPTURE: begin
          if (w_beat) begin
            r_buf[int'(r_seg)*DW +: DW] <= s_axis_tdata;
            if (s_axis_tlast || r_seg == 3'(HDR_SEGS-1)) begin
              r_tail_pending <= ~s_axis_tlast;
              r_tready       <= 1'b0;
              r_state        <= ST_LOOKUP;
            end else begin
              r_seg <= r_seg + 3'd1;
            end
          end
        end
        ST_LOOKUP: begin
          r_state <= ST_EXTRACT;
        end
        ST_EXTRACT: begin
          for (int c = 0; c < 8; c++) begin
            r_c2[c] <= w_c2_next[c];
            r_c4[c] <= w_c4_next[c];
            r_c6[c] <= w_c6_next[c];
          end
          r_state <= ST_OUTPUT;
        end
        ST_OUTPUT: begin
          // First OUTPUT cycle registers the assembled PHV; it is then held
          // untouched until the downstream handshake.
          if (!r_phv_valid) begin
            r_phv_valid <= 1'b1;
            r_phv_out   <= w_phv_asm;
          end else if (phv_ready) begin
            r_phv_valid <= 1'b0;
            r_tready    <= 1'b1;
            r_state     <= r_tail_pending ? ST_DRAIN : ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (w_beat && s_axis_tlast)
            r_state <= ST_IDLE;
        end
        default: begin
          r_state  <= ST_IDLE;
          r_tready <= 1'b0;
        end
      endcase
    end
  end

endmodule
